// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, bar colours and pattern-mode encoding for the LCD raster generator.
package lcd_timing_pkg;

    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_H_FP     = 2;
    localparam int DEF_H_SYNC   = 41;
    localparam int DEF_H_BP     = 2;
    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_V_FP     = 2;
    localparam int DEF_V_SYNC   = 10;
    localparam int DEF_V_BP     = 2;
    localparam int BAR_W        = 60;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_GRID  = 2'd1,
        MODE_GRAD  = 2'd2,
        MODE_BLACK = 2'd3
    } mode_e;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/lcd_pattern_gen.sv
// Registered RGB565 test-pattern stage; one clock of latency, black whenever de is low.
module lcd_pattern_gen
    import lcd_timing_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  x_i,
    input  logic [8:0]  y_i,
    input  logic        de_i,
    input  logic [1:0]  mode_i,
    input  logic [2:0]  bar_idx_i,
    output logic [15:0] rgb_o
);

    logic [15:0] rgb_d, rgb_q;

    always_comb begin
        rgb_d = RGB_BLACK;
        if (de_i) begin
            case (mode_i)
                MODE_BARS: rgb_d = bar_colour(bar_idx_i);
                MODE_GRID: rgb_d = (x_i[3:0] == 4'd0 || y_i[3:0] == 4'd0) ? RGB_WHITE : RGB_BLACK;
                MODE_GRAD: rgb_d = {x_i[8:4], y_i[8:3], ~x_i[8:4]};
                default:   rgb_d = RGB_BLACK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rgb_q <= RGB_BLACK;
        else     rgb_q <= rgb_d;
    end

    assign rgb_o = rgb_q;

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster counters, sync/DE generation and frame-locked pattern selection for the 480x272 LCD.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  mode,
    output logic        lcd_de,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic [15:0] lcd_rgb,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
    localparam logic [8:0] VS_BEG = 9'(V_ACTIVE + V_FP);
    localparam logic [8:0] VS_END = 9'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [5:0] BAR_LAST = 6'(BAR_W - 1);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [8:0] v_cnt_q, v_cnt_d;
    logic [5:0] bar_px_q, bar_px_d;
    logic [2:0] bar_idx_q, bar_idx_d;
    logic [1:0] mode_q, mode_d;
    logic       origin, de_c, hs_c, vs_c;

    logic       de_q, hs_q, vs_q, fs_q;
    logic [9:0] x_q;
    logic [8:0] y_q;

    assign origin = (h_cnt_q == 10'd0) && (v_cnt_q == 9'd0);
    assign de_c   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hs_c   = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign vs_c   = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

    // The pattern latches mode only at the frame origin, so the origin pixel already uses the new mode.
    assign mode_d = origin ? mode : mode_q;

    always_comb begin
        h_cnt_d   = h_cnt_q + 10'd1;
        v_cnt_d   = v_cnt_q;
        bar_px_d  = bar_px_q + 6'd1;
        bar_idx_d = bar_idx_q;
        if (bar_px_q == BAR_LAST) begin
            bar_px_d  = 6'd0;
            bar_idx_d = bar_idx_q + 3'd1;
        end
        if (h_cnt_q == H_LAST) begin
            h_cnt_d   = 10'd0;
            bar_px_d  = 6'd0;
            bar_idx_d = 3'd0;
            v_cnt_d   = (v_cnt_q == V_LAST) ? 9'd0 : v_cnt_q + 9'd1;
        end
        if (!en) begin
            h_cnt_d   = 10'd0;
            v_cnt_d   = 9'd0;
            bar_px_d  = 6'd0;
            bar_idx_d = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q   <= 10'd0;
            v_cnt_q   <= 9'd0;
            bar_px_q  <= 6'd0;
            bar_idx_q <= 3'd0;
            mode_q    <= MODE_BARS;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
            mode_q    <= mode_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || !en) begin
            de_q <= 1'b0;
            hs_q <= ~SYNC_POL;
            vs_q <= ~SYNC_POL;
            x_q  <= 10'd0;
            y_q  <= 9'd0;
            fs_q <= 1'b0;
        end else begin
            de_q <= de_c;
            hs_q <= hs_c ? SYNC_POL : ~SYNC_POL;
            vs_q <= vs_c ? SYNC_POL : ~SYNC_POL;
            x_q  <= de_c ? h_cnt_q : 10'd0;
            y_q  <= de_c ? v_cnt_q : 9'd0;
            fs_q <= origin;
        end
    end

    lcd_pattern_gen u_pattern (
        .clk       (clk),
        .rst       (rst),
        .x_i       (h_cnt_q[8:0]),
        .y_i       (v_cnt_q),
        .de_i      (en && de_c),
        .mode_i    (mode_d),
        .bar_idx_i (bar_idx_q),
        .rgb_o     (lcd_rgb)
    );

    assign lcd_de      = de_q;
    assign lcd_hsync   = hs_q;
    assign lcd_vsync   = vs_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign frame_start = fs_q;

endmodule
